// File: rtl/fifo_ctrl_ram.sv
// FIFO sequencer for a 2^ADDR_WIDTH x N dual-pointer RAM: turns push/pop into RAM strobes and pointers.
// Latency: write/read strobes are combinational; count/flags/error visible the cycle after the edge; data_valid 1 cycle after read.
// Backpressure: ready_o low in INIT (and ERROR); pushes while full need a same-cycle pop, pops while empty are dropped.
//
// Ports: clk_i, reset_i (async active-high); push_i/pop_i requests; almost_full_th_i/almost_empty_th_i
//        (latched on the INIT->IDLE edge); write_o/read_o/wr_ptr_o/rd_ptr_o drive the RAM;
//        count_o, full_o, empty_o, almost_full_o, almost_empty_o, error_o, data_valid_o, ready_o status.
// Optional macro FIFO_CTRL_STICKY_ERR_EN: overflow/underflow locks the controller in ERROR until reset;
// without it error_o is a one-cycle pulse and the offending request is simply dropped.
module fifo_ctrl_ram #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [ADDR_WIDTH-1:0] almost_full_th_i,
    input  logic [ADDR_WIDTH-1:0] almost_empty_th_i,
    output logic                  write_o,
    output logic                  read_o,
    output logic [ADDR_WIDTH-1:0] wr_ptr_o,
    output logic [ADDR_WIDTH-1:0] rd_ptr_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic                  error_o,
    output logic                  data_valid_o,
    output logic                  ready_o
);

    localparam logic [1:0] ST_INIT   = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;
`ifdef FIFO_CTRL_STICKY_ERR_EN
    localparam logic [1:0] ST_ERROR  = 2'd3;
`endif

    localparam int                  DEPTH_INT = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH   = DEPTH_INT[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = 1;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH-1:0] af_th_q, af_th_d;
    logic [ADDR_WIDTH-1:0] ae_th_q, ae_th_d;
    logic                  full_q, empty_q, af_q, ae_q, error_q, dv_q;
    logic                  error_d;
    logic                  ready;
    logic                  push_acc, pop_acc, overflow, underflow;
    logic [ADDR_WIDTH-1:0] af_th_eff, ae_th_eff;

    assign ready = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);

    // A pop frees the slot a same-cycle push needs, so full only blocks a lone push.
    assign pop_acc   = ready && pop_i && !empty_q;
    assign push_acc  = ready && push_i && (!full_q || pop_acc);
    assign overflow  = ready && push_i && full_q && !pop_acc;
    assign underflow = ready && pop_i && empty_q;

    // Thresholds are being latched on the INIT edge, so the flags computed on
    // that same edge must use the live inputs rather than the stale registers.
    assign af_th_eff = (state_q == ST_INIT) ? almost_full_th_i  : af_th_q;
    assign ae_th_eff = (state_q == ST_INIT) ? almost_empty_th_i : ae_th_q;

    always_comb begin
        wr_ptr_d = push_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop_acc  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        if (push_acc && !pop_acc) begin
            count_d = count_q + CNT_ONE;
        end else if (!push_acc && pop_acc) begin
            count_d = count_q - CNT_ONE;
        end
        af_th_d = (state_q == ST_INIT) ? almost_full_th_i  : af_th_q;
        ae_th_d = (state_q == ST_INIT) ? almost_empty_th_i : ae_th_q;

        state_d = state_q;
        case (state_q)
            ST_INIT:   state_d = ST_IDLE;
            ST_IDLE,
            ST_ACTIVE: state_d = (count_d == '0) ? ST_IDLE : ST_ACTIVE;
            default:   state_d = state_q;
        endcase

`ifdef FIFO_CTRL_STICKY_ERR_EN
        error_d = error_q || overflow || underflow;
        if (ready && (overflow || underflow)) begin
            state_d = ST_ERROR;
        end
`else
        error_d = overflow || underflow;
`endif
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ST_INIT;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            af_th_q  <= '0;
            ae_th_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            error_q  <= 1'b0;
            dv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            af_th_q  <= af_th_d;
            ae_th_q  <= ae_th_d;
            full_q   <= (count_d == DEPTH);
            empty_q  <= (count_d == '0);
            af_q     <= (count_d >= {1'b0, af_th_eff});
            ae_q     <= (count_d <= {1'b0, ae_th_eff});
            error_q  <= error_d;
            dv_q     <= pop_acc;
        end
    end

    assign write_o        = push_acc;
    assign read_o         = pop_acc;
    assign wr_ptr_o       = wr_ptr_q;
    assign rd_ptr_o       = rd_ptr_q;
    assign count_o        = count_q;
    assign full_o         = full_q;
    assign empty_o        = empty_q;
    assign almost_full_o  = af_q;
    assign almost_empty_o = ae_q;
    assign error_o        = error_q;
    assign data_valid_o   = dv_q;
    assign ready_o        = ready;

endmodule

// File: tb/tb_fifo_ctrl_ram.sv
// Bench for fifo_ctrl_ram with a behavioural 64 x 4 RAM and a data scoreboard.
// Latency: inputs driven 1 ns after the rising edge, outputs sampled there or on the falling edge.
// Backpressure: the bench only issues pushes it expects to be accepted into the scoreboard.
module tb_fifo_ctrl_ram;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [AW-1:0] af_th = 6'd48;
    logic [AW-1:0] ae_th = 6'd8;
    logic          wr, rd, full, empty, af, ae, err, dv, ready;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    logic [3:0] din = 4'h0;
    logic [3:0] dout = 4'h0;
    logic [3:0] mem [64];
    logic [3:0] exp_q [$];
    int n_checks = 0;
    int n_errors = 0;

    fifo_ctrl_ram #(.ADDR_WIDTH(AW)) dut (
        .clk_i(clk), .reset_i(rst), .push_i(push), .pop_i(pop),
        .almost_full_th_i(af_th), .almost_empty_th_i(ae_th),
        .write_o(wr), .read_o(rd), .wr_ptr_o(wr_ptr), .rd_ptr_o(rd_ptr),
        .count_o(count), .full_o(full), .empty_o(empty),
        .almost_full_o(af), .almost_empty_o(ae), .error_o(err),
        .data_valid_o(dv), .ready_o(ready)
    );

    always #5 clk = ~clk;

    // RAM: registered read port, so data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (wr) mem[wr_ptr] <= din;
        if (rd) dout <= mem[rd_ptr];
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Scoreboard consumer: every data_valid must match the oldest pushed word.
    always @(negedge clk) begin
        if (!rst && dv) begin
            if (exp_q.size() == 0) check("dv_spurious", {31'b0, dv}, 32'd0);
            else                   check("rdata", {28'b0, dout}, {28'b0, exp_q.pop_front()});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rst_vals(input string tag);
        check({tag, "_ready"}, {31'b0, ready}, 0);
        check({tag, "_count"}, {25'b0, count}, 0);
        check({tag, "_empty"}, {31'b0, empty}, 1);
        check({tag, "_aempty"}, {31'b0, ae}, 1);
        check({tag, "_full"}, {31'b0, full}, 0);
        check({tag, "_afull"}, {31'b0, af}, 0);
        check({tag, "_error"}, {31'b0, err}, 0);
        check({tag, "_dv"}, {31'b0, dv}, 0);
        check({tag, "_wrptr"}, {26'b0, wr_ptr}, 0);
        check({tag, "_rdptr"}, {26'b0, rd_ptr}, 0);
        check({tag, "_write"}, {31'b0, wr}, 0);
        check({tag, "_read"}, {31'b0, rd}, 0);
    endtask

    task automatic reset_and_init();
        rst = 1'b1; push = 1'b0; pop = 1'b0;
        #1;
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        cyc();
    endtask

    logic [3:0] vals [3];

    initial begin
        vals[0] = 4'hA; vals[1] = 4'h5; vals[2] = 4'hC;

        // Reset, with requests asserted to show the strobes stay low.
        #1 rst = 1'b1;
        push = 1'b1; pop = 1'b1;
        #2 check_rst_vals("rst");
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("init_ready", {31'b0, ready}, 0);
        check("init_write", {31'b0, wr}, 0);
        check("init_read", {31'b0, rd}, 0);
        cyc();
        push = 1'b0; pop = 1'b0;
        check("idle_ready", {31'b0, ready}, 1);
        check("idle_count", {25'b0, count}, 0);
        check("idle_error", {31'b0, err}, 0);
        check("idle_empty", {31'b0, empty}, 1);
        check("idle_aempty", {31'b0, ae}, 1);

        // Fill: 64 pushes, pointer walk and flag thresholds.
        for (int i = 0; i < 64; i++) begin
            check("fill_wrptr", {26'b0, wr_ptr}, i);
            push = 1'b1; din = i[3:0];
            #1 check("fill_write", {31'b0, wr}, 1);
            exp_q.push_back(din);
            cyc();
            check("fill_count", {25'b0, count}, i + 1);
            check("fill_afull", {31'b0, af}, (i + 1 >= 48) ? 1 : 0);
            check("fill_aempty", {31'b0, ae}, (i + 1 <= 8) ? 1 : 0);
            check("fill_full", {31'b0, full}, (i + 1 == 64) ? 1 : 0);
        end
        push = 1'b0;
        check("fill_wrap", {26'b0, wr_ptr}, 0);

        // Full with simultaneous push and pop.
        push = 1'b1; pop = 1'b1; din = 4'hF;
        #1;
        check("fp_write", {31'b0, wr}, 1);
        check("fp_read", {31'b0, rd}, 1);
        exp_q.push_back(din);
        cyc();
        push = 1'b0; pop = 1'b0;
        check("fp_count", {25'b0, count}, 64);
        check("fp_wrptr", {26'b0, wr_ptr}, 1);
        check("fp_rdptr", {26'b0, rd_ptr}, 1);
        check("fp_error", {31'b0, err}, 0);
        check("fp_full", {31'b0, full}, 1);
        check("fp_dv", {31'b0, dv}, 1);

`ifndef FIFO_CTRL_STICKY_ERR_EN
        // Overflow: dropped, one-cycle error pulse.
        push = 1'b1;
        #1 check("ovf_write", {31'b0, wr}, 0);
        cyc();
        push = 1'b0;
        check("ovf_error", {31'b0, err}, 1);
        check("ovf_count", {25'b0, count}, 64);
        check("ovf_wrptr", {26'b0, wr_ptr}, 1);
        cyc();
        check("ovf_pulse", {31'b0, err}, 0);
`endif

        // Drain back to back; the scoreboard checks every word.
        for (int i = 0; i < 64; i++) begin
            pop = 1'b1;
            #1 check("drain_read", {31'b0, rd}, 1);
            cyc();
        end
        pop = 1'b0;
        check("drain_count", {25'b0, count}, 0);
        check("drain_empty", {31'b0, empty}, 1);
        check("drain_rdptr", {26'b0, rd_ptr}, 1);
        cyc();

        // Empty with simultaneous push and pop: push wins, pop is an underflow.
        push = 1'b1; pop = 1'b1; din = 4'h7;
        #1;
        check("ep_write", {31'b0, wr}, 1);
        check("ep_read", {31'b0, rd}, 0);
        exp_q.push_back(din);
        cyc();
        push = 1'b0; pop = 1'b0;
        check("ep_count", {25'b0, count}, 1);
        check("ep_error", {31'b0, err}, 1);
        check("ep_empty", {31'b0, empty}, 0);
        cyc();
`ifdef FIFO_CTRL_STICKY_ERR_EN
        check("ep_sticky", {31'b0, err}, 1);
        check("ep_ready", {31'b0, ready}, 0);
`else
        check("ep_pulse", {31'b0, err}, 0);
        check("ep_ready", {31'b0, ready}, 1);
`endif
        reset_and_init();

        // Three words then three pops.
        for (int i = 0; i < 3; i++) begin
            push = 1'b1; din = vals[i];
            exp_q.push_back(din);
            cyc();
        end
        push = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pop = 1'b1;
            #1 check("abc_read", {31'b0, rd}, 1);
            cyc();
            check("abc_dv", {31'b0, dv}, 1);
        end
        pop = 1'b0;
        cyc();
        check("abc_dv_end", {31'b0, dv}, 0);
        check("abc_empty", {31'b0, empty}, 1);

        // Mid-stream reset at count 20 with a pop in flight.
        for (int i = 0; i < 21; i++) begin
            push = 1'b1; din = i[3:0];
            exp_q.push_back(din);
            cyc();
        end
        push = 1'b0;
        pop = 1'b1;
        cyc();
        pop = 1'b0;
        check("mid_count", {25'b0, count}, 20);
        check("mid_dv", {31'b0, dv}, 1);
        #1;
        push = 1'b1; pop = 1'b1; rst = 1'b1;
        #1 check_rst_vals("midrst");
        exp_q.delete();
        push = 1'b0; pop = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        cyc();
        check("post_ready", {31'b0, ready}, 1);
        pop = 1'b1;
        #1 check("post_read", {31'b0, rd}, 0);
        cyc();
        pop = 1'b0;
        check("post_error", {31'b0, err}, 1);
        check("post_count", {25'b0, count}, 0);
        check("post_rdptr", {26'b0, rd_ptr}, 0);
        cyc();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
